// File: rtl/svc_uart_monitor_if.sv
// Decoded-character stream between the UART monitor and its consumer.
// The master drives valid/data and holds them until the slave accepts.
interface svc_uart_monitor_if #(
    parameter int DATA_BITS = 8
);
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/svc_uart_monitor.sv
// UART TX line monitor: decodes frames into a valid/ready stream and raises
// end-of-test, watchdog and line-error indications for a simulation harness.
module svc_uart_monitor #(
    parameter int         CLOCK_FREQ_HZ   = 25_000_000,
    parameter int         BAUD_RATE       = 115_200,
    parameter int         DATA_BITS       = 8,
    parameter int         PARITY          = 0,
    parameter int         STOP_BITS       = 1,
    parameter int         WATCHDOG_CYCLES = 500_000,
    parameter logic [7:0] EOT_CHAR        = 8'h04
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    svc_uart_monitor_if.master         m,
    output logic                       frame_err,
    output logic                       parity_err,
    output logic                       overrun,
    output logic                       eot,
    output logic                       timeout,
    output logic                       done,
    output logic [31:0]                byte_count
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int SYNC_STAGES  = 2;
    localparam int EOT_W        = (DATA_BITS < 8) ? DATA_BITS : 8;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [31:0]      WD_LIMIT  = 32'(WATCHDOG_CYCLES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_prev_reg;
    logic                   rx_sync;
    logic                   rx_fall;

    logic [2:0]             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [3:0]             bit_idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bit_reg;
    logic                   frame_flag_reg;

    logic                   valid_reg;
    logic [DATA_BITS-1:0]   data_reg;
    logic                   frame_err_reg;
    logic                   parity_err_reg;
    logic                   overrun_reg;
    logic                   eot_reg;
    logic                   timeout_reg;
    logic [31:0]            count_reg;
    logic [31:0]            wd_reg;

    logic                   tick;
    logic                   frame_done;
    logic                   frame_bad;
    logic                   par_bad;
    logic                   stalled;
    logic                   deliver;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx};
            rx_prev_reg <= rx_sync;
        end
    end

    assign rx_sync = sync_reg[SYNC_STAGES-1];
    assign rx_fall = rx_prev_reg & ~rx_sync;

    assign tick       = (cnt_reg == '0);
    assign frame_done = (state_reg == ST_STOP) && tick && (bit_idx_reg == LAST_STOP);
    assign frame_bad  = frame_flag_reg | ~rx_sync;
    assign stalled    = valid_reg && !m.m_ready;
    assign deliver    = frame_done && !frame_bad && !par_bad && !stalled;

    always_comb begin
        par_bad = 1'b0;
        if (PARITY == 1)
            par_bad = ~(^shift_reg ^ par_bit_reg);
        else if (PARITY == 2)
            par_bad = ^shift_reg ^ par_bit_reg;
    end

    // Bit timer runs in every non-idle state; a tick marks the mid-bit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            par_bit_reg    <= 1'b0;
            frame_flag_reg <= 1'b0;
        end else begin
            if (state_reg != ST_IDLE)
                cnt_reg <= tick ? FULL_LOAD : cnt_reg - 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_fall) begin
                        cnt_reg   <= HALF_LOAD;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_sync) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg   <= ST_DATA;
                            bit_idx_reg <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx_reg == LAST_DATA) begin
                            bit_idx_reg    <= '0;
                            frame_flag_reg <= 1'b0;
                            state_reg      <= (PARITY != 0) ? ST_PAR : ST_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (tick) begin
                        par_bit_reg <= rx_sync;
                        state_reg   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        frame_flag_reg <= frame_bad;
                        if (bit_idx_reg == LAST_STOP)
                            state_reg <= ST_IDLE;
                        else
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Completion priority: framing, then parity, then overrun, then delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            eot_reg        <= 1'b0;
            count_reg      <= '0;
        end else begin
            frame_err_reg  <= frame_done && frame_bad;
            parity_err_reg <= frame_done && !frame_bad && par_bad;
            overrun_reg    <= frame_done && !frame_bad && !par_bad && stalled;
            if (deliver) begin
                valid_reg <= 1'b1;
                data_reg  <= shift_reg;
                count_reg <= count_reg + 32'd1;
                if (shift_reg[EOT_W-1:0] == EOT_CHAR[EOT_W-1:0])
                    eot_reg <= 1'b1;
            end else if (valid_reg && m.m_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    // Any frame completion counts as line activity; the count freezes once done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (frame_done)
                wd_reg <= '0;
            else if (!done && WATCHDOG_CYCLES != 0)
                wd_reg <= wd_reg + 32'd1;
            if (WATCHDOG_CYCLES != 0 && !done && wd_reg == WD_LIMIT)
                timeout_reg <= 1'b1;
        end
    end

    assign m.m_valid  = valid_reg;
    assign m.m_data   = data_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;
    assign eot        = eot_reg;
    assign timeout    = timeout_reg;
    assign done       = eot_reg | timeout_reg;
    assign byte_count = count_reg;

endmodule
